// File: rtl/core_dmem_axil.sv
// -----------------------------------------------------------------------------
// core_dmem_axil
//   AXI4-Lite slave data memory for the core's load/store stage. A word-wide
//   RAM with byte-lane write strobes. The write and read channels run as two
//   independent FSMs. Each channel has one outstanding transaction.
//
//   Optional feature macro: DMEM_WR_FWD_EN
//     undefined : a read that hits the word committed on the same edge returns
//                 the pre-write word (read-before-write).
//     defined   : that read returns the old word with the strobed write bytes
//                 merged in (write-first). Out-of-range writes never forward.
//
//   Parameters
//     AXI_AWIDTH  byte-address width; word index = addr[AXI_AWIDTH-1:2]
//     AXI_DWIDTH  data width (32 only)
//     DEPTH_WORDS RAM depth in words (<= 2**(AXI_AWIDTH-2))
//
//   Ports
//     CLK, NRST                      clock (rising edge), async active-low reset
//     AXI_AW*  / AXI_W* / AXI_B*     write address, write data, write response
//     AXI_AR*  / AXI_R*              read address, read data/response
//     Responses: 2'b00 OKAY, 2'b10 SLVERR (word index >= DEPTH_WORDS)
// -----------------------------------------------------------------------------
module core_dmem_axil #(
  parameter int AXI_AWIDTH  = 12,
  parameter int AXI_DWIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                    CLK,
  input  logic                    NRST,
  input  logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  input  logic                    AXI_AWVALID,
  output logic                    AXI_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  input  logic                    AXI_WVALID,
  output logic                    AXI_WREADY,
  output logic [1:0]              AXI_BRESP,
  output logic                    AXI_BVALID,
  input  logic                    AXI_BREADY,
  input  logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  input  logic                    AXI_ARVALID,
  output logic                    AXI_ARREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  output logic [1:0]              AXI_RRESP,
  output logic                    AXI_RVALID,
  input  logic                    AXI_RREADY
);

  localparam int IW = AXI_AWIDTH - 2;
  localparam int MW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int SW = AXI_DWIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_RESP} rstate_e;

  function automatic logic in_range(input logic [IW-1:0] idx);
    return 32'(idx) < 32'(DEPTH_WORDS);
  endfunction

  function automatic logic [AXI_DWIDTH-1:0] merge_lanes(input logic [AXI_DWIDTH-1:0] old_w,
                                                        input logic [AXI_DWIDTH-1:0] new_w,
                                                        input logic [SW-1:0]         strb);
    logic [AXI_DWIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  logic [AXI_DWIDTH-1:0] mem [DEPTH_WORDS];

  // Byte-offset bits never select anything; lanes come from WSTRB only.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{AXI_AWADDR[1:0], AXI_ARADDR[1:0]};

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  wstate_e               wstate_q, wstate_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [IW-1:0]         awidx_q;
  logic [AXI_DWIDTH-1:0] wdata_q;
  logic [SW-1:0]         wstrb_q;

  logic                  aw_fire, w_fire;
  logic                  commit, latch_addr, latch_data;
  logic [IW-1:0]         c_idx;
  logic [AXI_DWIDTH-1:0] c_data;
  logic [SW-1:0]         c_strb;
  logic                  c_inrange;

  assign aw_fire   = AXI_AWVALID & AXI_AWREADY;
  assign w_fire    = AXI_WVALID & AXI_WREADY;
  assign c_inrange = in_range(c_idx);

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wstate_q <= W_IDLE;
      bresp_q  <= RESP_OKAY;
    end else begin
      wstate_q <= wstate_d;
      bresp_q  <= bresp_d;
    end
  end

  // Commit operands: whichever half was latched earlier comes from the
  // holding register, the other half straight from the bus.
  always_comb begin
    wstate_d   = wstate_q;
    bresp_d    = bresp_q;
    commit     = 1'b0;
    latch_addr = 1'b0;
    latch_data = 1'b0;
    c_idx      = AXI_AWADDR[AXI_AWIDTH-1:2];
    c_data     = AXI_WDATA;
    c_strb     = AXI_WSTRB;
    unique case (wstate_q)
      W_IDLE: begin
        if (aw_fire && w_fire) begin
          commit   = 1'b1;
          wstate_d = W_RESP;
        end else if (aw_fire) begin
          latch_addr = 1'b1;
          wstate_d   = W_HAVE_ADDR;
        end else if (w_fire) begin
          latch_data = 1'b1;
          wstate_d   = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        c_idx = awidx_q;
        if (w_fire) begin
          commit   = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        c_data = wdata_q;
        c_strb = wstrb_q;
        if (aw_fire) begin
          commit   = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (AXI_BREADY) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
    if (commit) bresp_d = c_inrange ? RESP_OKAY : RESP_SLVERR;
  end

  // Readies are decoded from state and forced low while NRST is asserted, so
  // they drop the instant reset asserts and are high in the first cycle after
  // release without waiting for an extra edge.
  always_comb begin
    AXI_AWREADY = NRST & ((wstate_q == W_IDLE) | (wstate_q == W_HAVE_DATA));
    AXI_WREADY  = NRST & ((wstate_q == W_IDLE) | (wstate_q == W_HAVE_ADDR));
    AXI_BVALID  = (wstate_q == W_RESP);
    AXI_BRESP   = bresp_q;
  end

  // Holding registers carry payload only; their reset value is irrelevant.
  always_ff @(posedge CLK) begin
    if (latch_addr) awidx_q <= AXI_AWADDR[AXI_AWIDTH-1:2];
    if (latch_data) begin
      wdata_q <= AXI_WDATA;
      wstrb_q <= AXI_WSTRB;
    end
  end

  always_ff @(posedge CLK) begin
    if (commit && c_inrange) begin
      for (int i = 0; i < SW; i++) begin
        if (c_strb[i]) mem[c_idx[MW-1:0]][8*i +: 8] <= c_data[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  rstate_e               rstate_q, rstate_d;
  logic [AXI_DWIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ar_fire;
  logic [IW-1:0]         r_idx;
  logic                  r_inrange;
  logic [AXI_DWIDTH-1:0] rd_word;

  assign ar_fire   = AXI_ARVALID & AXI_ARREADY;
  assign r_idx     = AXI_ARADDR[AXI_AWIDTH-1:2];
  assign r_inrange = in_range(r_idx);

  // The RAM sample is the value before this edge's commit, which gives
  // read-before-write on a same-word collision unless forwarding is built.
  always_comb begin
    rd_word = mem[r_idx[MW-1:0]];
`ifdef DMEM_WR_FWD_EN
    if (commit && c_inrange && (c_idx == r_idx)) rd_word = merge_lanes(rd_word, c_data, c_strb);
`endif
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rstate_q == R_IDLE) begin
      if (ar_fire) begin
        rstate_d = R_RESP;
        rdata_d  = r_inrange ? rd_word : '0;
        rresp_d  = r_inrange ? RESP_OKAY : RESP_SLVERR;
      end
    end else if (AXI_RREADY) begin
      rstate_d = R_IDLE;
    end
  end

  always_comb begin
    AXI_ARREADY = NRST & (rstate_q == R_IDLE);
    AXI_RVALID  = (rstate_q == R_RESP);
    AXI_RDATA   = rdata_q;
    AXI_RRESP   = rresp_q;
  end

endmodule

// File: tb/tb_core_dmem_axil.sv
module tb_core_dmem_axil;

  localparam int AW    = 13;
  localparam int DEPTH = 1024;

  logic        CLK, NRST;
  logic [AW-1:0] AXI_AWADDR, AXI_ARADDR;
  logic        AXI_AWVALID, AXI_AWREADY;
  logic [31:0] AXI_WDATA;
  logic [3:0]  AXI_WSTRB;
  logic        AXI_WVALID, AXI_WREADY;
  logic [1:0]  AXI_BRESP;
  logic        AXI_BVALID, AXI_BREADY;
  logic        AXI_ARVALID, AXI_ARREADY;
  logic [31:0] AXI_RDATA;
  logic [1:0]  AXI_RRESP;
  logic        AXI_RVALID, AXI_RREADY;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: word index -> word, only words the bench has written.
  logic [31:0] model [int];

  core_dmem_axil #(.AXI_AWIDTH(AW), .AXI_DWIDTH(32), .DEPTH_WORDS(DEPTH)) dut (
    .CLK(CLK), .NRST(NRST),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] apply_strb(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    if (idx < DEPTH) model[idx] = apply_strb(model.exists(idx) ? model[idx] : 32'h0, d, s);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive one write: AW after awd cycles, W after wd cycles, BREADY after bd
  // cycles of BVALID. lat = cycles between last handshake and BVALID.
  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awd, input int wd, input int bd,
                          output logic [1:0] resp, output int lat, output bit ok);
    bit aw_done, w_done, fa, fw;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; ok = 0; lat = -1; resp = 2'bxx;
    AXI_AWADDR = addr; AXI_WDATA = data; AXI_WSTRB = strb; AXI_BREADY = 1'b0;
    while (!(aw_done && w_done) && cyc < 50) begin
      AXI_AWVALID = !aw_done && (cyc >= awd);
      AXI_WVALID  = !w_done && (cyc >= wd);
      fa = AXI_AWVALID && AXI_AWREADY;
      fw = AXI_WVALID && AXI_WREADY;
      tick();
      if (fa) aw_done = 1;
      if (fw) w_done = 1;
      cyc++;
    end
    AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
    if (!(aw_done && w_done)) return;
    lat = 0;
    while (!AXI_BVALID && lat < 20) begin tick(); lat++; end
    if (!AXI_BVALID) return;
    resp = AXI_BRESP;
    for (int i = 0; i < bd; i++) begin
      tick();
      if (AXI_BVALID !== 1'b1 || AXI_BRESP !== resp) return;
    end
    AXI_BREADY = 1'b1;
    tick();
    AXI_BREADY = 1'b0;
    ok = 1;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int rd,
                         output logic [31:0] data, output logic [1:0] resp, output int lat, output bit ok);
    bit done, fa;
    int cyc;
    done = 0; cyc = 0; ok = 0; lat = -1; data = 'x; resp = 2'bxx;
    AXI_ARADDR = addr; AXI_RREADY = 1'b0;
    while (!done && cyc < 50) begin
      AXI_ARVALID = 1'b1;
      fa = AXI_ARREADY;
      tick();
      if (fa) done = 1;
      cyc++;
    end
    AXI_ARVALID = 1'b0;
    if (!done) return;
    lat = 0;
    while (!AXI_RVALID && lat < 20) begin tick(); lat++; end
    if (!AXI_RVALID) return;
    data = AXI_RDATA; resp = AXI_RRESP;
    for (int i = 0; i < rd; i++) begin
      tick();
      if (AXI_RVALID !== 1'b1 || AXI_RDATA !== data || AXI_RRESP !== resp) return;
    end
    AXI_RREADY = 1'b1;
    tick();
    AXI_RREADY = 1'b0;
    ok = 1;
  endtask

  task automatic test_reset();
    NRST = 1'b0;
    AXI_AWADDR = '0; AXI_AWVALID = 0; AXI_WDATA = '0; AXI_WSTRB = '0; AXI_WVALID = 0;
    AXI_BREADY = 0; AXI_ARADDR = '0; AXI_ARVALID = 0; AXI_RREADY = 0;
    repeat (3) tick();
    n_tests++;
    if ({AXI_AWREADY, AXI_WREADY, AXI_ARREADY, AXI_BVALID, AXI_RVALID} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_hs: got %b expected 00000",
               {AXI_AWREADY, AXI_WREADY, AXI_ARREADY, AXI_BVALID, AXI_RVALID});
    end
    n_tests++;
    if ({AXI_BRESP, AXI_RRESP, AXI_RDATA} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_payload: got bresp=%b rresp=%b rdata=%h expected 0", AXI_BRESP, AXI_RRESP, AXI_RDATA);
    end
    NRST = 1'b1;
    #1;
    n_tests++;
    if ({AXI_AWREADY, AXI_WREADY, AXI_ARREADY} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 111", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY});
    end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [1:0] r; logic [31:0] d; int lat; bit ok;
    do_write(13'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, r, lat, ok);
    model_write(13'h010 >> 2, 32'hDEADBEEF, 4'hF);
    n_tests++;
    if (ok !== 1'b1 || lat !== 0 || r !== 2'b00) begin
      n_fail++; $display("FAIL tp1_write: ok=%0d lat=%0d bresp=%b expected ok=1 lat=0 bresp=00", ok, lat, r);
    end
    do_read(13'h010, 0, d, r, lat, ok);
    n_tests++;
    if (ok !== 1'b1 || lat !== 0 || r !== 2'b00 || d !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL tp1_read: ok=%0d lat=%0d rresp=%b rdata=%h expected 1/0/00/deadbeef", ok, lat, r, d);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r; logic [31:0] d, exp_w; int lat; bit ok;
    AXI_WDATA = 32'h000000AA; AXI_WSTRB = 4'b0001; AXI_WVALID = 1; AXI_BREADY = 0;
    tick();
    AXI_WVALID = 0;
    for (int c = 1; c <= 3; c++) begin
      n_tests++;
      if (AXI_WREADY !== 1'b0 || AXI_AWREADY !== 1'b1 || AXI_BVALID !== 1'b0) begin
        n_fail++; $display("FAIL tp2_wait_c%0d: wready=%b awready=%b bvalid=%b expected 0 1 0",
                           c, AXI_WREADY, AXI_AWREADY, AXI_BVALID);
      end
      if (c == 3) begin AXI_AWADDR = 13'h010; AXI_AWVALID = 1; end
      tick();
    end
    AXI_AWVALID = 0;
    model_write(13'h010 >> 2, 32'h000000AA, 4'b0001);
    n_tests++;
    if (AXI_BVALID !== 1'b1 || AXI_BRESP !== 2'b00) begin
      n_fail++; $display("FAIL tp2_bvalid: bvalid=%b bresp=%b expected 1 00", AXI_BVALID, AXI_BRESP);
    end
    AXI_BREADY = 1; tick(); AXI_BREADY = 0;
    exp_w = model[4];
    do_read(13'h010, 0, d, r, lat, ok);
    n_tests++;
    if (ok !== 1'b1 || r !== 2'b00 || d !== exp_w || d !== 32'hDEADBEAA) begin
      n_fail++; $display("FAIL tp2_read: ok=%0d rresp=%b rdata=%h expected deadbeaa", ok, r, d);
    end
  endtask

  task automatic test_b_backpressure();
    logic [1:0] r; logic [31:0] d, wd; int lat; bit ok;
    wd = $urandom;
    AXI_AWADDR = 13'h044; AXI_WDATA = wd; AXI_WSTRB = 4'hF;
    AXI_AWVALID = 1; AXI_WVALID = 1; AXI_BREADY = 0;
    tick();
    AXI_AWVALID = 0; AXI_WVALID = 0;
    model_write(13'h044 >> 2, wd, 4'hF);
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if ({AXI_BVALID, AXI_BRESP, AXI_AWREADY, AXI_WREADY} !== 5'b1_00_00) begin
        n_fail++; $display("FAIL tp3_hold_c%0d: bvalid,bresp,awready,wready=%b expected 10000",
                           c, {AXI_BVALID, AXI_BRESP, AXI_AWREADY, AXI_WREADY});
      end
      tick();
    end
    AXI_BREADY = 1; tick(); AXI_BREADY = 0;
    n_tests++;
    if (AXI_AWREADY !== 1'b1 || AXI_BVALID !== 1'b0) begin
      n_fail++; $display("FAIL tp3_release: awready=%b bvalid=%b expected 1 0", AXI_AWREADY, AXI_BVALID);
    end
    do_read(13'h044, 1, d, r, lat, ok);
    n_tests++;
    if (ok !== 1'b1 || lat !== 0 || d !== model[17]) begin
      n_fail++; $display("FAIL tp3_read: ok=%0d lat=%0d rdata=%h expected %h", ok, lat, d, model[17]);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [31:0] d; int lat; bit ok;
    do_write(13'h000, 32'hCAFEF00D, 4'hF, 0, 0, 0, r, lat, ok);
    model_write(0, 32'hCAFEF00D, 4'hF);
    do_write(13'h1000, 32'h12345678, 4'hF, 0, 0, 0, r, lat, ok);
    n_tests++;
    if (ok !== 1'b1 || r !== 2'b10) begin
      n_fail++; $display("FAIL tp4_write_resp: ok=%0d bresp=%b expected 10", ok, r);
    end
    do_read(13'h1000, 0, d, r, lat, ok);
    n_tests++;
    if (ok !== 1'b1 || r !== 2'b10 || d !== 32'h0) begin
      n_fail++; $display("FAIL tp4_read: ok=%0d rresp=%b rdata=%h expected 10 00000000", ok, r, d);
    end
    do_read(13'h000, 0, d, r, lat, ok);
    n_tests++;
    if (ok !== 1'b1 || r !== 2'b00 || d !== model[0]) begin
      n_fail++; $display("FAIL tp4_ram_unchanged: rdata=%h expected %h", d, model[0]);
    end
  endtask

  task automatic test_collision();
    logic [1:0] r; logic [31:0] d, old_w, exp_r; int lat; bit ok;
    do_write(13'h020, 32'h11223344, 4'hF, 0, 0, 0, r, lat, ok);
    model_write(8, 32'h11223344, 4'hF);
    old_w = model[8];
`ifdef DMEM_WR_FWD_EN
    exp_r = apply_strb(old_w, 32'hFFFFFFFF, 4'b1100);
`else
    exp_r = old_w;
`endif
    AXI_AWADDR = 13'h020; AXI_WDATA = 32'hFFFFFFFF; AXI_WSTRB = 4'b1100;
    AXI_ARADDR = 13'h020;
    AXI_AWVALID = 1; AXI_WVALID = 1; AXI_ARVALID = 1; AXI_BREADY = 0; AXI_RREADY = 0;
    tick();
    AXI_AWVALID = 0; AXI_WVALID = 0; AXI_ARVALID = 0;
    model_write(8, 32'hFFFFFFFF, 4'b1100);
    n_tests++;
    if (AXI_RVALID !== 1'b1 || AXI_RDATA !== exp_r || AXI_BVALID !== 1'b1) begin
      n_fail++; $display("FAIL tp5_collision: rvalid=%b rdata=%h bvalid=%b expected 1 %h 1",
                         AXI_RVALID, AXI_RDATA, AXI_BVALID, exp_r);
    end
    AXI_BREADY = 1; AXI_RREADY = 1; tick(); AXI_BREADY = 0; AXI_RREADY = 0;
    do_read(13'h020, 0, d, r, lat, ok);
    n_tests++;
    if (ok !== 1'b1 || d !== model[8] || d !== 32'hFFFF3344) begin
      n_fail++; $display("FAIL tp5_after: rdata=%h expected ffff3344", d);
    end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] r; logic [31:0] d, v; int lat; bit ok;
    v = $urandom;
    do_write(13'h030, v, 4'hF, 0, 0, 0, r, lat, ok);
    model_write(12, v, 4'hF);
    AXI_AWADDR = 13'h030; AXI_AWVALID = 1; AXI_WVALID = 0;
    AXI_ARADDR = 13'h030; AXI_ARVALID = 1; AXI_RREADY = 0; AXI_BREADY = 0;
    tick();
    AXI_AWVALID = 0; AXI_ARVALID = 0;
    n_tests++;
    if ({AXI_AWREADY, AXI_WREADY, AXI_RVALID} !== 3'b011) begin
      n_fail++; $display("FAIL tp6_pre: awready,wready,rvalid=%b expected 011", {AXI_AWREADY, AXI_WREADY, AXI_RVALID});
    end
    #2 NRST = 1'b0;
    #1;
    n_tests++;
    if ({AXI_AWREADY, AXI_WREADY, AXI_ARREADY, AXI_BVALID, AXI_RVALID} !== 5'b0) begin
      n_fail++; $display("FAIL tp6_in_reset: got %b expected 00000",
                         {AXI_AWREADY, AXI_WREADY, AXI_ARREADY, AXI_BVALID, AXI_RVALID});
    end
    tick();
    NRST = 1'b1;
    AXI_BREADY = 1; AXI_RREADY = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if ({AXI_BVALID, AXI_RVALID, AXI_AWREADY} !== 3'b001) begin
        n_fail++; $display("FAIL tp6_dropped_c%0d: bvalid,rvalid,awready=%b expected 001",
                           c, {AXI_BVALID, AXI_RVALID, AXI_AWREADY});
      end
    end
    AXI_BREADY = 0; AXI_RREADY = 0;
    do_read(13'h030, 0, d, r, lat, ok);
    n_tests++;
    if (ok !== 1'b1 || d !== model[12]) begin
      n_fail++; $display("FAIL tp6_ram: ok=%0d rdata=%h expected %h", ok, d, model[12]);
    end
  endtask

  task automatic test_random();
    logic [1:0] r, er; logic [31:0] d, wd, ed; logic [3:0] s; int lat, idx; bit ok;
    logic [AW-1:0] a;
    for (int k = 0; k < 8; k++) begin
      wd = $urandom;
      a = AW'(k * 37 * 4);
      do_write(a, wd, 4'hF, 0, 0, 0, r, lat, ok);
      model_write(k * 37, wd, 4'hF);
    end
    for (int op = 0; op < 80; op++) begin
      if ($urandom_range(0, 7) == 0) idx = DEPTH + $urandom_range(0, 1023);
      else idx = $urandom_range(0, 7) * 37;
      a = {idx[AW-3:0], 2'($urandom_range(0, 3))};
      er = (idx < DEPTH) ? 2'b00 : 2'b10;
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom; s = 4'($urandom_range(0, 15));
        do_write(a, wd, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r, lat, ok);
        model_write(idx, wd, s);
        n_tests++;
        if (ok !== 1'b1 || lat !== 0 || r !== er) begin
          n_fail++; $display("FAIL rnd_write op%0d idx%0d: ok=%0d lat=%0d bresp=%b expected 1 0 %b",
                             op, idx, ok, lat, r, er);
        end
      end else begin
        ed = (idx < DEPTH) ? model[idx] : 32'h0;
        do_read(a, $urandom_range(0, 2), d, r, lat, ok);
        n_tests++;
        if (ok !== 1'b1 || lat !== 0 || r !== er || d !== ed) begin
          n_fail++; $display("FAIL rnd_read op%0d idx%0d: ok=%0d lat=%0d rresp=%b rdata=%h expected 1 0 %b %h",
                             op, idx, ok, lat, r, d, er, ed);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_w_before_aw();
    test_b_backpressure();
    test_out_of_range();
    test_collision();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_dmem_axil.md
Name: core_dmem_axil

Overview:
AXI4-Lite slave data memory. It sits directly downstream of the core's load/store stage and serves that stage's AXI master for loads and stores. It holds a word-organised RAM with byte-lane write strobes. Write and read channels are handled independently, and each has one outstanding transaction at a time.

Parameters:
AXI_AWIDTH, 12, byte-address width; word index = addr[AXI_AWIDTH-1:2]
AXI_DWIDTH, 32, data width; only 32 supported
DEPTH_WORDS, 1024, number of 32-bit words; must be <= 2^(AXI_AWIDTH-2)

Ports:
CLK  in  1  clock, rising edge
NRST  in  1  asynchronous active-low reset
AXI_AWADDR  in  AXI_AWIDTH  write address
AXI_AWVALID  in  1  write address valid
AXI_AWREADY  out  1  write address ready
AXI_WDATA  in  32  write data, byte-lane aligned
AXI_WSTRB  in  4  byte-lane enables
AXI_WVALID  in  1  write data valid
AXI_WREADY  out  1  write data ready
AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR
AXI_BVALID  out  1  write response valid
AXI_BREADY  in  1  write response ready
AXI_ARADDR  in  AXI_AWIDTH  read address
AXI_ARVALID  in  1  read address valid
AXI_ARREADY  out  1  read address ready
AXI_RDATA  out  32  read data, full word, unshifted
AXI_RRESP  out  2  read response: 00 OKAY, 10 SLVERR
AXI_RVALID  out  1  read data valid
AXI_RREADY  in  1  read data ready

Behaviour:
- Reset: asynchronous on NRST low.
  - Clears all handshake/FSM state. AWREADY, WREADY, ARREADY, BVALID, RVALID = 0 while NRST is low; BRESP, RRESP, RDATA = 0.
  - RAM contents are not cleared.
  - Any in-flight transaction is dropped; no B or R beat is issued for it.
  - First cycle after reset release: AWREADY = WREADY = ARREADY = 1.
- Handshake: a beat transfers on a rising edge with VALID & READY. Outputs are registered. A VALID output is held with payload stable until its READY is seen.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: AWREADY = WREADY = 1.
    - AW and W both fire in the same cycle -> commit, go to W_RESP.
    - Only AW fires -> latch addr, go to W_HAVE_ADDR.
    - Only W fires -> latch data and strb, go to W_HAVE_DATA.
  - W_HAVE_ADDR: AWREADY = 0, WREADY = 1. W fires -> commit, go to W_RESP.
  - W_HAVE_DATA: WREADY = 0, AWREADY = 1. AW fires -> commit, go to W_RESP.
  - W_RESP: AWREADY = WREADY = 0, BVALID = 1. BREADY -> go to W_IDLE (BVALID low next cycle).
  - Commit is on the edge of the last handshake. BVALID rises the cycle after; write latency is 1 cycle.
  - Commit writes byte lane i when strb[i] = 1. WSTRB = 0000 is a legal no-op with BRESP = OKAY.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: ARREADY = 1. AR fires -> RAM read; RDATA/RRESP registered; RVALID = 1 next cycle; go to R_RESP.
  - R_RESP: ARREADY = 0, hold until RREADY, then go to R_IDLE.
  - Read latency: 1 cycle. Maximum throughput: 1 read per 2 cycles when RREADY is held high.
- Range check: word index >= DEPTH_WORDS -> SLVERR.
  - Write: no RAM change.
  - Read: RDATA = 0.
  - Low address bits [1:0] are ignored; lane selection is by WSTRB only.
- Same-edge collision (write commit and AR handshake to the same word): read returns the pre-write word (read-before-write), unless the optional feature below is enabled.
- Read and write FSMs are fully independent; neither blocks the other.

Optional Feature:
- Macro: DMEM_WR_FWD_EN.
- Defined: on a same-edge collision, RDATA = old word with each byte lane i replaced by the write data byte where strb[i] = 1 (write-first). No forwarding if the write is out of range.
- Undefined: read-before-write as specified above; no forwarding logic is built.

Test Plan:
1. Reset release, AW and W fire the same cycle: addr 0x010, data 0xDEADBEEF, strb 1111 -> BVALID the next cycle, BRESP = 00. Then AR 0x010 -> RVALID one cycle after, RDATA = 0xDEADBEEF, RRESP = 00.
2. W before AW: W 0x000000AA strb 0001 at cycle 0, AW 0x010 at cycle 3 -> WREADY = 0 during cycles 1-3, BVALID at cycle 4. Read of 0x010 then gives 0xDEADBEAA.
3. BREADY held low for 5 cycles -> BVALID and BRESP stay stable, AWREADY = WREADY = 0 throughout. BREADY high -> AWREADY = 1 the next cycle.
4. Out of range, DEPTH_WORDS = 1024: write 0x1000 with AXI_AWIDTH = 13 -> BRESP = 10, RAM unchanged. Read 0x1000 -> RRESP = 10, RDATA = 0.
5. Same-edge collision on 0x020, old word 0x11223344, write 0xFFFFFFFF strb 1100 -> RDATA = 0x11223344 without the macro, 0xFFFF3344 with DMEM_WR_FWD_EN.
6. NRST pulsed low while in W_HAVE_ADDR and R_RESP -> all VALID/READY outputs low immediately. After release: no BVALID/RVALID for dropped transactions, and the RAM word is unchanged.
